control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle hardwired control unit for the bus-based 32-bit RISC datapath. Every cycle it drives every datapath strobe: bus-out selects, register-in enables, memory read/write, ALU operation and register-select (Gra/Grb/Grc) lines.
- It runs fetch / decode / execute micro-step sequences from the opcode in the datapath IR.
- It handles reset, stop and halt, and reports run status to the top level.

Parameters:
- IR_WIDTH, 32, instruction register width.
- OP_LSB, 27, LSB of the 5-bit opcode field; the opcode is ir[OP_LSB+4:OP_LSB].

Ports:
- clock  in  1  system clock, rising-edge active.
- reset  in  1  asynchronous, active-high reset.
- ir  in  IR_WIDTH  current IR contents from the datapath.
- con_ff  in  1  branch-condition flip-flop output from the datapath.
- stop  in  1  level request to halt after the current instruction completes.
- ctrl  out  27  datapath strobe vector; bit map is defined in the package.
- alu_op  out  5  ALU operation select.
- clear  out  1  synchronous datapath register clear.
- run  out  1  high while executing; low when halted.
- state_dbg  out  5  current state encoding, for bench observation.

Behaviour:
- Reset (asynchronous): state goes to RST. While in RST: clear=1, run=1, ctrl=0, alu_op=0.
- RST always moves to T0 on the next edge.
- All outputs are Moore decodes of (state, latched opcode). The opcode is latched on the rising edge that leaves T2. A decoded output is active for exactly one cycle per micro-step.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Execute micro-steps, beginning at T3 (Tn = step n). After the last step, the next state is T0, or HALTED if stop is sampled high in that last cycle.
  - ALU reg-reg (add, sub, and, or, ror, rol, shr, shra, shl):
    - T3: Grb, Rout, Yin.
    - T4: Grc, Rout, Zin, alu_op=opcode.
    - T5: Zlowout, Gra, Rin.
  - Immediate (addi, andi, ori): same as reg-reg, but T4 uses Cout instead of Grc, Rout. alu_op = 3, 5 or 6 respectively.
  - mul, div:
    - T3: Gra, Rout, Yin.
    - T4: Grb, Rout, Zin, alu_op=opcode.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
  - neg, not:
    - T3: Grb, Rout, Zin, alu_op=opcode.
    - T4: Zlowout, Gra, Rin.
  - ld:
    - T3: Grb, BAout, Yin.
    - T4: Cout, Zin, alu_op=3.
    - T5: Zlowout, MARin.
    - T6: Read, MDRin.
    - T7: MDRout, Gra, Rin.
  - ldi:
    - T3 and T4: as ld.
    - T5: Zlowout, Gra, Rin.
  - st:
    - T3 to T5: as ld.
    - T6: Gra, Rout, MDRin.
    - T7: Write.
  - br:
    - T3: Gra, Rout, CONin.
    - T4: PCout, Yin.
    - T5: Cout, Zin, alu_op=3.
    - T6: Zlowout and PCin only if con_ff=1 at T6; otherwise ctrl=0.
  - jr:
    - T3: Gra, Rout, PCin.
  - jal:
    - T3: PCout, Grb, Rin.
    - T4: Gra, Rout, PCin.
  - Single-step transfers, all at T3:
    - in: InPortout, Gra, Rin.
    - out: Gra, Rout, OutPortin.
    - mfhi: HIout, Gra, Rin.
    - mflo: LOout, Gra, Rin.
  - nop, and opcodes 28 to 31: after T2 go directly to T0 (or HALTED if stop).
  - halt: after T2 go to HALTED.
- HALTED: run=0, ctrl=0. The only exit is reset.
- stop asserted during fetch: the fetched instruction still completes.
- Reset mid-instruction: the sequence is abandoned immediately, with no partial Write or Rin after the reset edge.
- alu_op=0 whenever no ALU op is active.

Decomposition:
- Package cpu_ctrl_pkg contains:
  - Opcode constants: ld 0, ldi 1, st 2, add 3, sub 4, and 5, or 6, ror 7, rol 8, shr 9, shra 10, shl 11, addi 12, andi 13, ori 14, mul 15, div 16, neg 17, not 18, br 19, jr 20, jal 21, in 22, out 23, mfhi 24, mflo 25, nop 26, halt 27.
  - State enum: RST, T0 to T7, HALTED.
  - ctrl bit indices, bit 0 upward: PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, MDRin, MDRout, Read, Write, IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, LOin, HIin, LOout, HIout, CONin, InPortout, OutPortin.
- Sub-module: one natural sub-module, ctrl_decode. It is a combinational (state, opcode, con_ff) to (ctrl, alu_op) table, instantiated under the state register / FSM.

Test Plan:
- Reset pulse, then idle: RST lasts 1 cycle with clear=1. T0 shows ctrl bits PCout|MARin|IncPC|Zin (0x0000000F), run=1.
- add (ir=0x18918000): T0 to T5 take 6 cycles. T4 shows alu_op=3 with Grc|Rout|Zin. T5 shows Zlowout|Gra|Rin. The next state is T0.
- st (ir=0x10000000 | fields): T7 shows Write only. Read is never asserted after T1.
- br: with con_ff=0, T6 ctrl=0. With con_ff=1, T6 shows Zlowout|PCin. Both cases return to T0.
- halt (opcode 27): after T2, run drops and state_dbg=HALTED, and it stays there for 20 cycles. Reset restarts at RST.
- stop raised at T4 of mul: T5 and T6 (LOin, then HIin) still occur, then HALTED. Separately, reset asserted at T6 of st: ctrl=0 immediately and Write is never seen.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the RISC control sequencer: opcodes, FSM states,
// datapath strobe bit positions and per-opcode micro-step lengths.
package cpu_ctrl_pkg;

   localparam int CTRL_W = 27;
   localparam int ALU_W  = 5;
   localparam int OP_W   = 5;

   typedef logic [OP_W-1:0] opcode_t;

   localparam opcode_t OP_LD   = 5'd0;
   localparam opcode_t OP_LDI  = 5'd1;
   localparam opcode_t OP_ST   = 5'd2;
   localparam opcode_t OP_ADD  = 5'd3;
   localparam opcode_t OP_SUB  = 5'd4;
   localparam opcode_t OP_AND  = 5'd5;
   localparam opcode_t OP_OR   = 5'd6;
   localparam opcode_t OP_ROR  = 5'd7;
   localparam opcode_t OP_ROL  = 5'd8;
   localparam opcode_t OP_SHR  = 5'd9;
   localparam opcode_t OP_SHRA = 5'd10;
   localparam opcode_t OP_SHL  = 5'd11;
   localparam opcode_t OP_ADDI = 5'd12;
   localparam opcode_t OP_ANDI = 5'd13;
   localparam opcode_t OP_ORI  = 5'd14;
   localparam opcode_t OP_MUL  = 5'd15;
   localparam opcode_t OP_DIV  = 5'd16;
   localparam opcode_t OP_NEG  = 5'd17;
   localparam opcode_t OP_NOT  = 5'd18;
   localparam opcode_t OP_BR   = 5'd19;
   localparam opcode_t OP_JR   = 5'd20;
   localparam opcode_t OP_JAL  = 5'd21;
   localparam opcode_t OP_IN   = 5'd22;
   localparam opcode_t OP_OUT  = 5'd23;
   localparam opcode_t OP_MFHI = 5'd24;
   localparam opcode_t OP_MFLO = 5'd25;
   localparam opcode_t OP_NOP  = 5'd26;
   localparam opcode_t OP_HALT = 5'd27;

   typedef enum logic [4:0] {
      RST = 5'd0, T0, T1, T2, T3, T4, T5, T6, T7, HALTED
   } state_t;

   localparam int CB_PCOUT     = 0;
   localparam int CB_MARIN     = 1;
   localparam int CB_INCPC     = 2;
   localparam int CB_ZIN       = 3;
   localparam int CB_ZLOWOUT   = 4;
   localparam int CB_ZHIGHOUT  = 5;
   localparam int CB_PCIN      = 6;
   localparam int CB_MDRIN     = 7;
   localparam int CB_MDROUT    = 8;
   localparam int CB_READ      = 9;
   localparam int CB_WRITE     = 10;
   localparam int CB_IRIN      = 11;
   localparam int CB_YIN       = 12;
   localparam int CB_GRA       = 13;
   localparam int CB_GRB       = 14;
   localparam int CB_GRC       = 15;
   localparam int CB_RIN       = 16;
   localparam int CB_ROUT      = 17;
   localparam int CB_BAOUT     = 18;
   localparam int CB_COUT      = 19;
   localparam int CB_LOIN      = 20;
   localparam int CB_HIIN      = 21;
   localparam int CB_LOOUT     = 22;
   localparam int CB_HIOUT     = 23;
   localparam int CB_CONIN     = 24;
   localparam int CB_INPORTOUT = 25;
   localparam int CB_OUTPORTIN = 26;

   // Index of the final micro-step for an opcode; fetch-only opcodes end at T2.
   function automatic logic [2:0] last_step(opcode_t op);
      case (op)
         OP_LD, OP_ST:                         return 3'd7;
         OP_MUL, OP_DIV, OP_BR:                return 3'd6;
         OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
         OP_ADDI, OP_ANDI, OP_ORI:             return 3'd5;
         OP_NEG, OP_NOT, OP_JAL:               return 3'd4;
         OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: return 3'd3;
         default:                              return 3'd2;
      endcase
   endfunction

   function automatic logic [2:0] state_step(state_t s);
      case (s)
         T1:      return 3'd1;
         T2:      return 3'd2;
         T3:      return 3'd3;
         T4:      return 3'd4;
         T5:      return 3'd5;
         T6:      return 3'd6;
         T7:      return 3'd7;
         default: return 3'd0;
      endcase
   endfunction

   function automatic state_t step_state(logic [2:0] n);
      case (n)
         3'd1:    return T1;
         3'd2:    return T2;
         3'd3:    return T3;
         3'd4:    return T4;
         3'd5:    return T5;
         3'd6:    return T6;
         3'd7:    return T7;
         default: return T0;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_ctrl_decode.sv
// Combinational micro-step table: (state, latched opcode, con_ff) to the
// datapath strobe vector and ALU operation select.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  state_t            i_state,
   input  opcode_t           i_opcode,
   input  logic              i_con_ff,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [ALU_W-1:0]  o_alu_op
);

   // Immediate forms reuse the ALU operation of their register counterpart.
   function automatic logic [ALU_W-1:0] alu_sel(opcode_t op);
      case (op)
         OP_ADDI: return OP_ADD;
         OP_ANDI: return OP_AND;
         OP_ORI:  return OP_OR;
         default: return op;
      endcase
   endfunction

   // Decode strobes for the current micro-step; everything idles at zero.
   always_comb begin
      o_ctrl   = '0;
      o_alu_op = '0;
      case (i_state)
         T0: begin
            o_ctrl[CB_PCOUT] = 1'b1; o_ctrl[CB_MARIN] = 1'b1;
            o_ctrl[CB_INCPC] = 1'b1; o_ctrl[CB_ZIN]   = 1'b1;
         end
         T1: begin
            o_ctrl[CB_ZLOWOUT] = 1'b1; o_ctrl[CB_PCIN]  = 1'b1;
            o_ctrl[CB_READ]    = 1'b1; o_ctrl[CB_MDRIN] = 1'b1;
         end
         T2: begin
            o_ctrl[CB_MDROUT] = 1'b1; o_ctrl[CB_IRIN] = 1'b1;
         end
         T3, T4, T5, T6, T7: begin
            case (i_opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
               OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin
                  case (i_state)
                     T3: begin
                        o_ctrl[CB_GRB] = 1'b1; o_ctrl[CB_ROUT] = 1'b1; o_ctrl[CB_YIN] = 1'b1;
                     end
                     T4: begin
                        o_ctrl[CB_ZIN] = 1'b1;
                        if (i_opcode inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
                           o_ctrl[CB_COUT] = 1'b1;
                        end else begin
                           o_ctrl[CB_GRC] = 1'b1; o_ctrl[CB_ROUT] = 1'b1;
                        end
                        o_alu_op = alu_sel(i_opcode);
                     end
                     T5: begin
                        o_ctrl[CB_ZLOWOUT] = 1'b1; o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_RIN] = 1'b1;
                     end
                     default: ;
                  endcase
               end
               OP_MUL, OP_DIV: begin
                  case (i_state)
                     T3: begin
                        o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_ROUT] = 1'b1; o_ctrl[CB_YIN] = 1'b1;
                     end
                     T4: begin
                        o_ctrl[CB_GRB] = 1'b1; o_ctrl[CB_ROUT] = 1'b1; o_ctrl[CB_ZIN] = 1'b1;
                        o_alu_op = i_opcode;
                     end
                     T5: begin o_ctrl[CB_ZLOWOUT]  = 1'b1; o_ctrl[CB_LOIN] = 1'b1; end
                     T6: begin o_ctrl[CB_ZHIGHOUT] = 1'b1; o_ctrl[CB_HIIN] = 1'b1; end
                     default: ;
                  endcase
               end
               OP_NEG, OP_NOT: begin
                  case (i_state)
                     T3: begin
                        o_ctrl[CB_GRB] = 1'b1; o_ctrl[CB_ROUT] = 1'b1; o_ctrl[CB_ZIN] = 1'b1;
                        o_alu_op = i_opcode;
                     end
                     T4: begin
                        o_ctrl[CB_ZLOWOUT] = 1'b1; o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_RIN] = 1'b1;
                     end
                     default: ;
                  endcase
               end
               OP_LD, OP_LDI, OP_ST: begin
                  case (i_state)
                     T3: begin
                        o_ctrl[CB_GRB] = 1'b1; o_ctrl[CB_BAOUT] = 1'b1; o_ctrl[CB_YIN] = 1'b1;
                     end
                     T4: begin
                        o_ctrl[CB_COUT] = 1'b1; o_ctrl[CB_ZIN] = 1'b1;
                        o_alu_op = OP_ADD;
                     end
                     T5: begin
                        o_ctrl[CB_ZLOWOUT] = 1'b1;
                        if (i_opcode == OP_LDI) begin
                           o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_RIN] = 1'b1;
                        end else begin
                           o_ctrl[CB_MARIN] = 1'b1;
                        end
                     end
                     T6: begin
                        if (i_opcode == OP_ST) begin
                           o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_ROUT] = 1'b1; o_ctrl[CB_MDRIN] = 1'b1;
                        end else begin
                           o_ctrl[CB_READ] = 1'b1; o_ctrl[CB_MDRIN] = 1'b1;
                        end
                     end
                     T7: begin
                        if (i_opcode == OP_ST) begin
                           o_ctrl[CB_WRITE] = 1'b1;
                        end else begin
                           o_ctrl[CB_MDROUT] = 1'b1; o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_RIN] = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
               OP_BR: begin
                  case (i_state)
                     T3: begin
                        o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_ROUT] = 1'b1; o_ctrl[CB_CONIN] = 1'b1;
                     end
                     T4: begin o_ctrl[CB_PCOUT] = 1'b1; o_ctrl[CB_YIN] = 1'b1; end
                     T5: begin
                        o_ctrl[CB_COUT] = 1'b1; o_ctrl[CB_ZIN] = 1'b1;
                        o_alu_op = OP_ADD;
                     end
                     T6: begin
                        // Branch target is only committed when the condition holds.
                        o_ctrl[CB_ZLOWOUT] = i_con_ff; o_ctrl[CB_PCIN] = i_con_ff;
                     end
                     default: ;
                  endcase
               end
               OP_JR: begin
                  if (i_state == T3) begin
                     o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_ROUT] = 1'b1; o_ctrl[CB_PCIN] = 1'b1;
                  end
               end
               OP_JAL: begin
                  if (i_state == T3) begin
                     o_ctrl[CB_PCOUT] = 1'b1; o_ctrl[CB_GRB] = 1'b1; o_ctrl[CB_RIN] = 1'b1;
                  end else if (i_state == T4) begin
                     o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_ROUT] = 1'b1; o_ctrl[CB_PCIN] = 1'b1;
                  end
               end
               OP_IN: if (i_state == T3) begin
                  o_ctrl[CB_INPORTOUT] = 1'b1; o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_RIN] = 1'b1;
               end
               OP_OUT: if (i_state == T3) begin
                  o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_ROUT] = 1'b1; o_ctrl[CB_OUTPORTIN] = 1'b1;
               end
               OP_MFHI: if (i_state == T3) begin
                  o_ctrl[CB_HIOUT] = 1'b1; o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_RIN] = 1'b1;
               end
               OP_MFLO: if (i_state == T3) begin
                  o_ctrl[CB_LOOUT] = 1'b1; o_ctrl[CB_GRA] = 1'b1; o_ctrl[CB_RIN] = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle hardwired control unit: fetch/decode/execute sequencing,
// stop/halt handling and run status for the bus-based RISC datapath.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int IR_WIDTH = 32,
   parameter int OP_LSB   = 27
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [IR_WIDTH-1:0] ir,
   input  logic                con_ff,
   input  logic                stop,
   output logic [CTRL_W-1:0]   ctrl,
   output logic [ALU_W-1:0]    alu_op,
   output logic                clear,
   output logic                run,
   output logic [4:0]          state_dbg
);

   state_t  r_state;
   state_t  w_next;
   opcode_t r_opcode;
   opcode_t w_ir_op;
   opcode_t w_op;
   logic    w_unused_ir;

   assign w_ir_op     = ir[OP_LSB+4:OP_LSB];
   assign w_unused_ir = ^ir;
   // During T2 the IR is still being read, so the sequence length comes from
   // the live field; later steps use the opcode latched when T2 was left.
   assign w_op        = (r_state == T2) ? w_ir_op : r_opcode;

   // State register and opcode latch; reset abandons any instruction at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= RST;
         r_opcode <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == T2) begin
            r_opcode <= w_ir_op;
         end
      end
   end

   // Next micro-step: advance until the opcode's last step, then refetch or halt.
   always_comb begin
      w_next = r_state;
      case (r_state)
         RST:    w_next = T0;
         T0:     w_next = T1;
         T1:     w_next = T2;
         HALTED: w_next = HALTED;
         default: begin
            if (r_state == T2 && w_op == OP_HALT) begin
               w_next = HALTED;
            end else if (state_step(r_state) >= last_step(w_op)) begin
               w_next = stop ? HALTED : T0;
            end else begin
               w_next = step_state(state_step(r_state) + 3'd1);
            end
         end
      endcase
   end

   // Status outputs decoded from the current state.
   always_comb begin
      clear     = (r_state == RST);
      run       = (r_state != HALTED);
      state_dbg = r_state;
   end

   ctrl_decode u_decode (
      .i_state  (r_state),
      .i_opcode (r_opcode),
      .i_con_ff (con_ff),
      .o_ctrl   (ctrl),
      .o_alu_op (alu_op)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: table of instructions, hand-written corner
// sequences and randomized instructions against a step-list reference model.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ir = '0;
   logic        con_ff = 1'b0;
   logic        stop = 1'b0;
   logic [26:0] ctrl;
   logic [4:0]  alu_op;
   logic        clear;
   logic        run;
   logic [4:0]  state_dbg;

   control_sequencer #(.IR_WIDTH(32), .OP_LSB(27)) dut (
      .clock(clock), .reset(reset), .ir(ir), .con_ff(con_ff), .stop(stop),
      .ctrl(ctrl), .alu_op(alu_op), .clear(clear), .run(run), .state_dbg(state_dbg)
   );

   always #5 clock = ~clock;

   localparam logic [26:0] PCOUT = 27'd1 << 0,  MARIN = 27'd1 << 1,  INCPC = 27'd1 << 2;
   localparam logic [26:0] ZIN = 27'd1 << 3,    ZLOW = 27'd1 << 4,   ZHIGH = 27'd1 << 5;
   localparam logic [26:0] PCIN = 27'd1 << 6,   MDRIN = 27'd1 << 7,  MDROUT = 27'd1 << 8;
   localparam logic [26:0] READ = 27'd1 << 9,   WRITE = 27'd1 << 10, IRIN = 27'd1 << 11;
   localparam logic [26:0] YIN = 27'd1 << 12,   GRA = 27'd1 << 13,   GRB = 27'd1 << 14;
   localparam logic [26:0] GRC = 27'd1 << 15,   RIN = 27'd1 << 16,   ROUT = 27'd1 << 17;
   localparam logic [26:0] BAOUT = 27'd1 << 18, COUT = 27'd1 << 19, LOIN = 27'd1 << 20;
   localparam logic [26:0] HIIN = 27'd1 << 21,  LOOUT = 27'd1 << 22, HIOUT = 27'd1 << 23;
   localparam logic [26:0] CONIN = 27'd1 << 24, INPORT = 27'd1 << 25, OUTPORT = 27'd1 << 26;

   localparam int S_RST = 0, S_T0 = 1, S_HALT = 9;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: the expected strobe word for every cycle of one instruction.
   typedef struct {
      logic [26:0] c;
      logic [4:0]  a;
   } step_t;
   step_t exp_q[$];

   function automatic void push(logic [26:0] c, int a);
      exp_q.push_back('{c: c, a: 5'(a)});
   endfunction

   function automatic void build(int op, bit con);
      exp_q.delete();
      push(PCOUT | MARIN | INCPC | ZIN, 0);
      push(ZLOW | PCIN | READ | MDRIN, 0);
      push(MDROUT | IRIN, 0);
      if (op >= 3 && op <= 11) begin
         push(GRB | ROUT | YIN, 0); push(GRC | ROUT | ZIN, op); push(ZLOW | GRA | RIN, 0);
      end else if (op >= 12 && op <= 14) begin
         push(GRB | ROUT | YIN, 0);
         push(COUT | ZIN, (op == 12) ? 3 : (op == 13) ? 5 : 6);
         push(ZLOW | GRA | RIN, 0);
      end else if (op == 15 || op == 16) begin
         push(GRA | ROUT | YIN, 0); push(GRB | ROUT | ZIN, op);
         push(ZLOW | LOIN, 0); push(ZHIGH | HIIN, 0);
      end else if (op == 17 || op == 18) begin
         push(GRB | ROUT | ZIN, op); push(ZLOW | GRA | RIN, 0);
      end else if (op <= 2) begin
         push(GRB | BAOUT | YIN, 0); push(COUT | ZIN, 3);
         if (op == 1) push(ZLOW | GRA | RIN, 0);
         else push(ZLOW | MARIN, 0);
         if (op == 0) begin push(READ | MDRIN, 0); push(MDROUT | GRA | RIN, 0); end
         if (op == 2) begin push(GRA | ROUT | MDRIN, 0); push(WRITE, 0); end
      end else begin
         case (op)
            19: begin
               push(GRA | ROUT | CONIN, 0); push(PCOUT | YIN, 0); push(COUT | ZIN, 3);
               push(con ? (ZLOW | PCIN) : 27'd0, 0);
            end
            20: push(GRA | ROUT | PCIN, 0);
            21: begin push(PCOUT | GRB | RIN, 0); push(GRA | ROUT | PCIN, 0); end
            22: push(INPORT | GRA | RIN, 0);
            23: push(GRA | ROUT | OUTPORT, 0);
            24: push(HIOUT | GRA | RIN, 0);
            25: push(LOOUT | GRA | RIN, 0);
            default: ;
         endcase
      end
   endfunction

   // Called at a negedge; leaves the DUT in T0 at a negedge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst.state", 32'(state_dbg), S_RST);
      chk("rst.ctrl", 32'(ctrl), 0);
      chk("rst.alu", 32'(alu_op), 0);
      chk("rst.clear", 32'(clear), 1);
      chk("rst.run", 32'(run), 1);
      @(negedge clock);
      reset = 1'b0;
      chk("rst.hold_state", 32'(state_dbg), S_RST);
      @(negedge clock);
      chk("t0.state", 32'(state_dbg), S_T0);
      chk("t0.ctrl", 32'(ctrl), 32'h0000000F);
      chk("t0.run", 32'(run), 1);
      chk("t0.clear", 32'(clear), 0);
   endtask

   // Runs one instruction from T0, comparing every cycle with the model.
   task automatic exec_instr(input int op, input bit con, input int stop_at,
                             output int len, output bit halted);
      int  cyc;
      bit  done;
      string nm;
      ir     = {5'(op), 27'($urandom)};
      con_ff = con;
      stop   = 1'b0;
      build(op, con);
      cyc  = 0;
      done = 0;
      while (!done && cyc < 16) begin
         nm = $sformatf("op%0d.c%0d", op, cyc);
         if (cyc < exp_q.size()) begin
            chk({nm, ".state"}, 32'(state_dbg), 32'(cyc + 1));
            chk({nm, ".ctrl"}, 32'(ctrl), 32'(exp_q[cyc].c));
            chk({nm, ".alu"}, 32'(alu_op), 32'(exp_q[cyc].a));
            chk({nm, ".run"}, 32'(run), 1);
            chk({nm, ".clear"}, 32'(clear), 0);
         end else begin
            chk({nm, ".overrun_state"}, 32'(state_dbg), S_T0);
         end
         if (cyc == stop_at) stop = 1'b1;
         @(negedge clock);
         cyc++;
         if (state_dbg == 5'(S_T0) || state_dbg == 5'(S_HALT)) done = 1;
      end
      if (!done) chk($sformatf("op%0d.timeout", op), 32'(state_dbg), S_T0);
      len    = cyc;
      halted = (state_dbg == 5'(S_HALT));
      chk($sformatf("op%0d.len", op), 32'(len), 32'(exp_q.size()));
      chk($sformatf("op%0d.halted", op), 32'(halted), 32'((op == 27) || (stop_at >= 0)));
      chk($sformatf("op%0d.end_run", op), 32'(run), 32'(!halted));
      if (halted) chk($sformatf("op%0d.halt_ctrl", op), 32'(ctrl), 0);
      stop = 1'b0;
   endtask

   typedef struct {
      int op;
      bit con;
      int stop_at;
      int exp_len;
      bit exp_halt;
   } vec_t;
   vec_t tbl[$];

   initial begin
      int len;
      bit h;
      @(negedge clock);
      do_reset();

      tbl.push_back('{3, 0, -1, 6, 0});   // add
      tbl.push_back('{4, 1, -1, 6, 0});   // sub
      tbl.push_back('{12, 0, -1, 6, 0});  // addi
      tbl.push_back('{13, 0, -1, 6, 0});  // andi
      tbl.push_back('{14, 0, -1, 6, 0});  // ori
      tbl.push_back('{15, 0, -1, 7, 0});  // mul
      tbl.push_back('{15, 0, 4, 7, 1});   // mul, stop raised at T4
      tbl.push_back('{16, 0, -1, 7, 0});  // div
      tbl.push_back('{17, 0, -1, 5, 0});  // neg
      tbl.push_back('{18, 0, -1, 5, 0});  // not
      tbl.push_back('{0, 0, -1, 8, 0});   // ld
      tbl.push_back('{1, 0, -1, 6, 0});   // ldi
      tbl.push_back('{2, 0, -1, 8, 0});   // st
      tbl.push_back('{19, 0, -1, 7, 0});  // br not taken
      tbl.push_back('{19, 1, -1, 7, 0});  // br taken
      tbl.push_back('{20, 0, -1, 4, 0});  // jr
      tbl.push_back('{21, 0, -1, 5, 0});  // jal
      tbl.push_back('{22, 0, -1, 4, 0});  // in
      tbl.push_back('{23, 0, -1, 4, 0});  // out
      tbl.push_back('{24, 0, -1, 4, 0});  // mfhi
      tbl.push_back('{25, 0, -1, 4, 0});  // mflo
      tbl.push_back('{26, 0, -1, 3, 0});  // nop
      tbl.push_back('{30, 0, -1, 3, 0});  // unused opcode
      tbl.push_back('{27, 0, -1, 3, 1});  // halt
      tbl.push_back('{3, 0, 1, 6, 1});    // add, stop during fetch
      tbl.push_back('{26, 0, 2, 3, 1});   // nop, stop at T2

      foreach (tbl[i]) begin
         exec_instr(tbl[i].op, tbl[i].con, tbl[i].stop_at, len, h);
         chk($sformatf("tbl%0d.len", i), 32'(len), 32'(tbl[i].exp_len));
         chk($sformatf("tbl%0d.halt", i), 32'(h), 32'(tbl[i].exp_halt));
         if (h) do_reset();
      end

      // halt must hold indefinitely until reset
      exec_instr(27, 0, -1, len, h);
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         chk($sformatf("halt_hold%0d.state", k), 32'(state_dbg), S_HALT);
         chk($sformatf("halt_hold%0d.run", k), 32'(run), 0);
         chk($sformatf("halt_hold%0d.ctrl", k), 32'(ctrl), 0);
      end
      do_reset();

      // reset asserted during T6 of st: Write must never reach the datapath
      ir = {5'd2, 27'h0123456};
      con_ff = 1'b0;
      repeat (6) @(negedge clock);
      chk("st_rst.at_t6_state", 32'(state_dbg), 7);
      chk("st_rst.at_t6_ctrl", 32'(ctrl), 32'(GRA | ROUT | MDRIN));
      do_reset();
      chk("st_rst.no_write", 32'(ctrl[10]), 0);
      exec_instr(3, 0, -1, len, h);

      // randomized instruction stream
      for (int n = 0; n < 40; n++) begin
         int op;
         int sa;
         bit c;
         op = int'($urandom_range(0, 31));
         c  = 1'($urandom_range(0, 1));
         sa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1;
         exec_instr(op, c, sa, len, h);
         if (h) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
